// File: rtl/clock_div_ctrl_if.sv
// Config handshake bundle for clock_div_ctrl: single-slot valid/ready ratio port.
interface clock_div_ctrl_if #(
    parameter int unsigned CNT_W = 26
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_half,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_half,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clock_div_ctrl.sv
// Run/stop and ratio controller for the slow-clock generator.
// clock_slow levels last exactly active_half clock_in cycles; ratio changes land
// only on toggle boundaries and a stop always parks clock_slow low.
// Optional: define CLKDIV_EDGE_CNT_EN to add the 16-bit rising-edge counter edge_cnt.
module clock_div_ctrl #(
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned DEFAULT_HALF = 50_000_000
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        run,
    clock_div_ctrl_if.slave cfg,
    output logic        clock_slow,
    output logic        tick,
    output logic [1:0]  state
`ifdef CLKDIV_EDGE_CNT_EN
    ,
    output logic [15:0] edge_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] active_half_q, active_half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clock_slow_q, clock_slow_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;
`ifdef CLKDIV_EDGE_CNT_EN
    logic [15:0]      edge_cnt_q, edge_cnt_d;
`endif

    logic term;
    logic toggle;
    logic handshake;
    logic cfg_ready_c;

    // Terminal count of the current level; only meaningful while clocking.
    assign term        = (state_q != IDLE) && (counter_q == (active_half_q - CNT_W'(1)));
    assign cfg_ready_c = !pend_vld_q && (state_q != STOP);
    assign handshake   = cfg.cfg_valid && cfg_ready_c;

    // Next-state: sequencing, level counting, config acceptance and pending apply.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        active_half_d = active_half_q;
        pend_half_d   = pend_half_q;
        pend_vld_d    = pend_vld_q;
        clock_slow_d  = clock_slow_q;
        tick_d        = 1'b0;
        cfg_err_d     = 1'b0;
        toggle        = 1'b0;
`ifdef CLKDIV_EDGE_CNT_EN
        edge_cnt_d    = edge_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                counter_d    = '0;
                clock_slow_d = 1'b0;
                if (run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!run && !clock_slow_q) begin
                    // Already at the park level: stop without toggling.
                    state_d   = IDLE;
                    counter_d = '0;
                end else begin
                    toggle    = term;
                    counter_d = term ? '0 : counter_q + CNT_W'(1);
                    if (!run) begin
                        // High level must finish in full before parking.
                        state_d = term ? IDLE : STOP;
                    end
                end
            end
            STOP: begin
                toggle    = term;
                counter_d = term ? '0 : counter_q + CNT_W'(1);
                if (term) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                counter_d = '0;
            end
        endcase

        if (toggle) begin
            clock_slow_d = !clock_slow_q;
            tick_d       = 1'b1;
`ifdef CLKDIV_EDGE_CNT_EN
            if (!clock_slow_q) begin
                edge_cnt_d = edge_cnt_q + 16'(1);
            end
`endif
        end

        // Pending ratio governs the level starting at this toggle, or on parking.
        if (pend_vld_q && (toggle || (state_d == IDLE))) begin
            active_half_d = pend_half_q;
            pend_vld_d    = 1'b0;
        end

        // A zero ratio is consumed but discarded; otherwise load direct or pending.
        if (handshake) begin
            if (cfg.cfg_half == '0) begin
                cfg_err_d = 1'b1;
            end else if ((state_q == IDLE) || (state_d == IDLE)) begin
                active_half_d = cfg.cfg_half;
            end else begin
                pend_half_d = cfg.cfg_half;
                pend_vld_d  = 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q       <= IDLE;
            counter_q     <= '0;
            active_half_q <= CNT_W'(DEFAULT_HALF);
            pend_half_q   <= '0;
            pend_vld_q    <= 1'b0;
            clock_slow_q  <= 1'b0;
            tick_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
`ifdef CLKDIV_EDGE_CNT_EN
            edge_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            active_half_q <= active_half_d;
            pend_half_q   <= pend_half_d;
            pend_vld_q    <= pend_vld_d;
            clock_slow_q  <= clock_slow_d;
            tick_q        <= tick_d;
            cfg_err_q     <= cfg_err_d;
`ifdef CLKDIV_EDGE_CNT_EN
            edge_cnt_q    <= edge_cnt_d;
`endif
        end
    end

    assign clock_slow    = clock_slow_q;
    assign tick          = tick_q;
    assign state         = state_q;
    assign cfg.cfg_ready = cfg_ready_c;
    assign cfg.cfg_err   = cfg_err_q;
`ifdef CLKDIV_EDGE_CNT_EN
    assign edge_cnt      = edge_cnt_q;
`endif

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl with DEFAULT_HALF=4.
module tb_clock_div_ctrl;

    localparam int unsigned CNT_W = 8;

    logic       clk;
    logic       reset;
    logic       run;
    logic       clock_slow;
    logic       tick;
    logic [1:0] state;
`ifdef CLKDIV_EDGE_CNT_EN
    logic [15:0] edge_cnt;
`endif

    int pass_cnt = 0;
    int total    = 0;

    clock_div_ctrl_if #(.CNT_W(CNT_W)) cfg_bus ();

    clock_div_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_HALF(4)
    ) dut (
        .clock_in  (clk),
        .reset     (reset),
        .run       (run),
        .cfg       (cfg_bus),
        .clock_slow(clock_slow),
        .tick      (tick),
        .state     (state)
`ifdef CLKDIV_EDGE_CNT_EN
        ,
        .edge_cnt  (edge_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until tick is seen; n = cycles taken, -1 on timeout.
    task automatic wait_toggle(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            n++;
            if (tick) break;
        end
        if (!tick) n = -1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        run   = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_half  = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (clock_slow !== 1'b0) $display("FAIL reset_clock_slow: got %b want 0", clock_slow); else pass_cnt++;
        total++; if (state !== 2'b00) $display("FAIL reset_state: got %b want 00", state); else pass_cnt++;
        total++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick); else pass_cnt++;
        total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", cfg_bus.cfg_ready); else pass_cnt++;
        total++; if (cfg_bus.cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b want 0", cfg_bus.cfg_err); else pass_cnt++;
    endtask

    task automatic test_run_basic();
        int n;
        apply_reset();
        run = 1'b1;
        step();
        total++; if (state !== 2'b01) $display("FAIL run_state: got %b want 01", state); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 4) $display("FAIL run_low_len: got %0d want 4", n); else pass_cnt++;
        total++; if (clock_slow !== 1'b1) $display("FAIL run_rise: got %b want 1", clock_slow); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 4) $display("FAIL run_high_len: got %0d want 4", n); else pass_cnt++;
        total++; if (clock_slow !== 1'b0) $display("FAIL run_fall: got %b want 0", clock_slow); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 4) $display("FAIL run_low2_len: got %0d want 4", n); else pass_cnt++;
    endtask

    task automatic test_cfg_run();
        int n;
        // Continue from a freshly risen high level (counter 0).
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half  = 8'd2;
        step();
        cfg_bus.cfg_valid = 1'b0;
        total++; if (cfg_bus.cfg_ready !== 1'b0) $display("FAIL cfgrun_ready_drop: got %b want 0", cfg_bus.cfg_ready); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 3) $display("FAIL cfgrun_high_rest: got %0d want 3", n); else pass_cnt++;
        total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL cfgrun_ready_back: got %b want 1", cfg_bus.cfg_ready); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 2) $display("FAIL cfgrun_new_len1: got %0d want 2", n); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 2) $display("FAIL cfgrun_new_len2: got %0d want 2", n); else pass_cnt++;
    endtask

    task automatic test_cfg_idle();
        int n;
        apply_reset();
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half  = 8'd0;
        step();
        cfg_bus.cfg_valid = 1'b0;
        total++; if (cfg_bus.cfg_err !== 1'b1) $display("FAIL zero_err_pulse: got %b want 1", cfg_bus.cfg_err); else pass_cnt++;
        step();
        total++; if (cfg_bus.cfg_err !== 1'b0) $display("FAIL zero_err_clear: got %b want 0", cfg_bus.cfg_err); else pass_cnt++;
        run = 1'b1;
        step();
        wait_toggle(n);
        total++; if (n !== 4) $display("FAIL zero_keep_low: got %0d want 4", n); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 4) $display("FAIL zero_keep_high: got %0d want 4", n); else pass_cnt++;
        // Non-zero ratio in IDLE loads directly.
        apply_reset();
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half  = 8'd3;
        step();
        cfg_bus.cfg_valid = 1'b0;
        total++; if (cfg_bus.cfg_err !== 1'b0) $display("FAIL idle_cfg_err: got %b want 0", cfg_bus.cfg_err); else pass_cnt++;
        run = 1'b1;
        step();
        wait_toggle(n);
        total++; if (n !== 3) $display("FAIL idle_cfg_len: got %0d want 3", n); else pass_cnt++;
    endtask

    task automatic test_stop();
        int n;
        int cnt;
        apply_reset();
        run = 1'b1;
        step();
        wait_toggle(n);
        run = 1'b0;
        step();
        cnt = 0;
        while (state == 2'b10 && cnt < 20) begin
            cnt++;
            step();
        end
        total++; if (cnt !== 3) $display("FAIL stop_cycles: got %0d want 3", cnt); else pass_cnt++;
        total++; if (state !== 2'b00) $display("FAIL stop_to_idle: got %b want 00", state); else pass_cnt++;
        total++; if (clock_slow !== 1'b0 || tick !== 1'b1) $display("FAIL stop_fall: got clk=%b tick=%b want clk=0 tick=1", clock_slow, tick); else pass_cnt++;
        step();
        step();
        total++; if (clock_slow !== 1'b0 || state !== 2'b00) $display("FAIL stop_parked: got clk=%b state=%b want 0/00", clock_slow, state); else pass_cnt++;
        run = 1'b1;
        step();
        wait_toggle(n);
        total++; if (n !== 4) $display("FAIL restart_low: got %0d want 4", n); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        apply_reset();
        run = 1'b1;
        step();
        wait_toggle(n);
        step();
        step();
        step();
        total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", cfg_bus.cfg_ready); else pass_cnt++;
        // Handshake lands on the terminal cycle of the high level.
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half  = 8'd3;
        step();
        cfg_bus.cfg_valid = 1'b0;
        total++; if (tick !== 1'b1 || clock_slow !== 1'b0) $display("FAIL b2b_term: got tick=%b clk=%b want 1/0", tick, clock_slow); else pass_cnt++;
        total++; if (cfg_bus.cfg_ready !== 1'b0) $display("FAIL b2b_pending: got %b want 0", cfg_bus.cfg_ready); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 4) $display("FAIL b2b_old_len: got %0d want 4", n); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 3) $display("FAIL b2b_new_len: got %0d want 3", n); else pass_cnt++;
    endtask

    task automatic test_reset_pending();
        int n;
        apply_reset();
        run = 1'b1;
        step();
        wait_toggle(n);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half  = 8'd2;
        step();
        cfg_bus.cfg_valid = 1'b0;
        total++; if (cfg_bus.cfg_ready !== 1'b0) $display("FAIL rstpend_busy: got %b want 0", cfg_bus.cfg_ready); else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (clock_slow !== 1'b0 || state !== 2'b00) $display("FAIL rstpend_idle: got clk=%b state=%b want 0/00", clock_slow, state); else pass_cnt++;
        total++; if (cfg_bus.cfg_ready !== 1'b1) $display("FAIL rstpend_ready: got %b want 1", cfg_bus.cfg_ready); else pass_cnt++;
`ifdef CLKDIV_EDGE_CNT_EN
        total++; if (edge_cnt !== 16'd0) $display("FAIL edge_cnt_reset: got %0d want 0", edge_cnt); else pass_cnt++;
`endif
        run = 1'b1;
        step();
        wait_toggle(n);
        total++; if (n !== 4) $display("FAIL rstpend_low: got %0d want 4", n); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 4) $display("FAIL rstpend_high: got %0d want 4", n); else pass_cnt++;
        wait_toggle(n);
        wait_toggle(n);
        wait_toggle(n);
`ifdef CLKDIV_EDGE_CNT_EN
        total++; if (edge_cnt !== 16'd3) $display("FAIL edge_cnt_three: got %0d want 3", edge_cnt); else pass_cnt++;
`endif
        total++; if (clock_slow !== 1'b1) $display("FAIL rstpend_third_rise: got %b want 1", clock_slow); else pass_cnt++;
    endtask

    task automatic test_half_one();
        int n;
        apply_reset();
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half  = 8'd1;
        step();
        cfg_bus.cfg_valid = 1'b0;
        run = 1'b1;
        step();
        wait_toggle(n);
        total++; if (n !== 1) $display("FAIL half1_first: got %0d want 1", n); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 1 || clock_slow !== 1'b0) $display("FAIL half1_second: got n=%0d clk=%b want 1/0", n, clock_slow); else pass_cnt++;
        wait_toggle(n);
        total++; if (n !== 1 || clock_slow !== 1'b1) $display("FAIL half1_third: got n=%0d clk=%b want 1/1", n, clock_slow); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_half  = '0;
        test_reset();
        test_run_basic();
        test_cfg_run();
        test_cfg_idle();
        test_stop();
        test_back_to_back();
        test_reset_pending();
        test_half_one();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
